// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/arith/branch ops, bit-serial shifts, valid/ready on both sides.
// Results are held in HOLD until the consumer takes them; a new op is accepted only from IDLE.
module multicycle_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  bcond
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [DATA_WIDTH-1:0]        r_result;
    logic                         r_bcond;
    logic [SHAMT_W-1:0]           r_cnt;
    logic [1:0]                   r_shop;
    logic                         w_accept;
    logic                         w_is_shift;
    logic [SHAMT_W-1:0]           w_shamt;
    logic [DATA_WIDTH-1:0]        w_diff;
    logic [DATA_WIDTH-1:0]        w_alu_res;
    logic                         w_alu_bcond;
    logic signed [DATA_WIDTH-1:0] w_a_s;
    logic signed [DATA_WIDTH-1:0] w_b_s;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == HOLD);
    assign result     = r_result;
    assign bcond      = r_bcond;
    assign w_accept   = in_valid & in_ready;
    assign w_shamt    = in_b[SHAMT_W-1:0];
    assign w_is_shift = (alu_op == 4'd5) || (alu_op == 4'd6) || (alu_op == 4'd7);
    assign w_a_s      = in_a;
    assign w_b_s      = in_b;
    assign w_diff     = in_a - in_b;

    // Shift ops load in_a unshifted; the SHIFT state does the actual work.
    always_comb begin
        w_alu_res   = '0;
        w_alu_bcond = 1'b0;
        case (alu_op)
            4'd0:                w_alu_res = in_a + in_b;
            4'd1:                w_alu_res = w_diff;
            4'd2:                w_alu_res = in_a ^ in_b;
            4'd3:                w_alu_res = in_a | in_b;
            4'd4:                w_alu_res = in_a & in_b;
            4'd5, 4'd6, 4'd7:    w_alu_res = in_a;
            4'd8: begin
                w_alu_res   = w_diff;
                w_alu_bcond = (in_a == in_b);
            end
            4'd9: begin
                w_alu_res   = w_diff;
                w_alu_bcond = (in_a != in_b);
            end
            4'd10: begin
                w_alu_res   = w_diff;
                w_alu_bcond = (w_a_s < w_b_s);
            end
            4'd11: begin
                w_alu_res   = w_diff;
                w_alu_bcond = (w_a_s >= w_b_s);
            end
            default: begin
                w_alu_res   = '0;
                w_alu_bcond = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_shamt != '0)) w_next = SHIFT;
                    else                               w_next = HOLD;
                end
            end
            SHIFT: begin
                if (r_cnt == SHAMT_W'(1)) w_next = HOLD;
            end
            HOLD: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_shop keeps alu_op[1:0]: 01 SLL, 10 SRL, 11 SRA.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_bcond  <= 1'b0;
            r_cnt    <= '0;
            r_shop   <= '0;
        end else if (w_accept) begin
            r_result <= w_alu_res;
            r_bcond  <= w_alu_bcond;
            r_cnt    <= w_shamt;
            r_shop   <= alu_op[1:0];
        end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt - SHAMT_W'(1);
            case (r_shop)
                2'b01:   r_result <= {r_result[DATA_WIDTH-2:0], 1'b0};
                2'b10:   r_result <= {1'b0, r_result[DATA_WIDTH-1:1]};
                default: r_result <= {r_result[DATA_WIDTH-1], r_result[DATA_WIDTH-1:1]};
            endcase
        end
    end

endmodule
